platform_field: RTL
===================

// Module: platform_field
// PURPOSE
//  Owns the scrolling set of platforms for the game. It sits beside jumplogic and feeds color_mapper.
//  Once per frame it scrolls every platform down when the ball climbs above the scroll line.
//  A platform leaving the bottom of the screen respawns at the top with an LFSR-random x.
//  Per pixel it returns a registered plat_on hit flag for the DrawX/DrawY being drawn.
// PARAMETERS
//  NUM_PLAT     8        number of platforms (index width 3)
//  PLAT_W       10'd40   platform width, pixels
//  PLAT_H       10'd8    platform height, pixels
//  SCREEN_H     10'd480  visible rows
//  SCROLL_LINE  10'd160  ball Y above which scrolling occurs
//  MAX_SCROLL   10'd8    max scroll per frame, pixels
//  SPACING      10'd60   reset vertical pitch
//  INIT_X0      10'd40   reset x of platform 0
//  INIT_DX      10'd72   reset x increment per index
// PORTS
//  Clk        in   1   system clock (50 MHz)
//  Reset      in   1   synchronous, active-high
//  frame_clk  in   1   VGA_VS, asynchronous to nothing but unsynchronised
//  BallY      in   10  ball centre Y from jumplogic
//  DrawX      in   10  current pixel X from vga_controller
//  DrawY      in   10  current pixel Y from vga_controller
//  plat_on    out  1   pixel lies on a platform; 1-cycle registered
//  scroll_amt out  10  pixels scrolled in the most recent frame; jumplogic uses it to hold the ball
//  busy       out  1   high during CALC/UPDATE
//  score      out  16  count of platform respawns, saturating at 16'hFFFF
// BEHAVIOUR
//  Reset (sync)
//   - State=IDLE; plat_on=0, scroll_amt=0, busy=0, score=0.
//   - y[i]=i*SPACING; x[i]=INIT_X0+i*INIT_DX; LFSR=10'h2A5; sync regs=0.
//   - Reset in any state aborts the sweep immediately; no partial updates survive.
//  Frame detect
//   - frame_clk passes through a 2-FF synchroniser.
//   - A rising edge (0->1 on the synced signal) is the frame event.
//  FSM
//   IDLE   - on frame event -> CALC.
//   CALC   - 1 cycle: scroll_amt <= (BallY<SCROLL_LINE) ? min(SCROLL_LINE-BallY, MAX_SCROLL) : 0.
//          - Index i<=0; -> UPDATE.
//   UPDATE - one platform per cycle, for i=0..NUM_PLAT-1: ny = y[i]+scroll_amt (10-bit).
//          - If ny>=SCREEN_H: y[i] <= ny-SCREEN_H; x[i] <= {1'b0,lfsr[8:0]} + (lfsr[9]?10'd64:0);
//            score++ (saturating).
//          - Else y[i] <= ny.
//          - After i=NUM_PLAT-1 -> IDLE.
//   - busy=1 in CALC and UPDATE. Sweep latency from event detection = 1+NUM_PLAT cycles.
//   - scroll_amt=0 still runs the sweep; no position changes.
//   - Frame events during CALC/UPDATE are ignored (not queued).
//  LFSR
//   - 10-bit Fibonacci, taps x^10+x^7+1, steps every Clk (including IDLE).
//   - All-zero state never occurs from the seed.
//   - Respawn x range 0..575, so x+PLAT_W stays within 640.
//  Pixel hit
//   - plat_on <= OR over i of (DrawX>=x[i] && DrawX<x[i]+PLAT_W && DrawY>=y[i] && DrawY<y[i]+PLAT_H).
//   - Registered; 1 cycle after DrawX/DrawY.
//   - Widths 11-bit internally so x+PLAT_W does not wrap.
//   - Sweep runs during vsync blanking; mixed old/new positions in that window are acceptable.
// TESTING
//  1 Reset, DrawX=40,DrawY=0 -> plat_on=1 next cycle; DrawX=80 -> 0; score=0, scroll_amt=0, busy=0.
//  2 BallY=300, pulse frame_clk -> busy high 9 cycles after sync, scroll_amt=0, all y unchanged.
//  3 BallY=150, frame -> scroll_amt=8 (capped from 10); y[1]=68; DrawX=112,DrawY=68 -> plat_on=1.
//  4 Force y[7]=476, BallY=156, frame -> scroll_amt=4, y[7]=0, x[7]=LFSR-derived <=575, score=1.
//  5 Second frame_clk edge mid-UPDATE -> ignored; exactly one sweep; score unchanged by the edge.
//  6 Assert Reset during UPDATE (i=3) -> next cycle IDLE, all y/x at reset pattern, score=0.

Source files
------------

// File: rtl/platform_field.sv
// platform_field: scrolling platform set with LFSR respawn and registered per-pixel hit flag
module platform_field (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_frame_clk,
    input  logic [9:0] i_ball_y,
    input  logic [9:0] i_draw_x,
    input  logic [9:0] i_draw_y,
    output logic       o_plat_on,
    output logic [9:0] o_scroll_amt,
    output logic       o_busy,
    output logic [15:0] o_score
);
    localparam int         NUM_PLAT    = 8;
    localparam logic [9:0] PLAT_W      = 10'd40;
    localparam logic [9:0] PLAT_H      = 10'd8;
    localparam logic [9:0] SCREEN_H    = 10'd480;
    localparam logic [9:0] SCROLL_LINE = 10'd160;
    localparam logic [9:0] MAX_SCROLL  = 10'd8;
    localparam int         SPACING     = 60;
    localparam int         INIT_X0     = 40;
    localparam int         INIT_DX     = 72;
    localparam logic [9:0] LFSR_SEED   = 10'h2A5;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_UPDATE} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [2:0]  r_idx;
    logic [2:0]  r_sync;
    logic [9:0]  r_lfsr;
    logic [9:0]  r_y [NUM_PLAT];
    logic [9:0]  r_x [NUM_PLAT];
    logic [9:0]  r_scroll;
    logic [15:0] r_score;
    logic        r_plat_on;
    logic        w_event;
    logic        w_hit;
    logic        w_wrap;
    logic [9:0]  w_ny;
    logic [9:0]  w_new_x;
    logic [9:0]  w_scroll;

    assign o_plat_on    = r_plat_on;
    assign o_scroll_amt = r_scroll;
    assign o_score      = r_score;

    // Frame edge, scroll amount and the candidate position of the platform under update
    always_comb begin
        w_event  = r_sync[1] & ~r_sync[2];
        w_scroll = (i_ball_y < SCROLL_LINE) ?
                   ((SCROLL_LINE - i_ball_y > MAX_SCROLL) ? MAX_SCROLL : SCROLL_LINE - i_ball_y) : 10'd0;
        w_ny     = r_y[r_idx] + r_scroll;
        w_wrap   = w_ny >= SCREEN_H;
        w_new_x  = {1'b0, r_lfsr[8:0]} + (r_lfsr[9] ? 10'd64 : 10'd0);
    end

    // Next-state and busy decode; frame events outside IDLE are dropped
    always_comb begin
        w_next = r_state;
        o_busy = r_state != S_IDLE;
        w_next = (r_state == S_IDLE)   ? (w_event ? S_CALC : S_IDLE) :
                 (r_state == S_CALC)   ? S_UPDATE :
                 (r_idx == 3'(NUM_PLAT - 1)) ? S_IDLE : S_UPDATE;
    end

    // Pixel hit test in 11 bits so x+PLAT_W and y+PLAT_H never wrap
    always_comb begin
        w_hit = 1'b0;
        for (int i = 0; i < NUM_PLAT; i++)
            w_hit = w_hit |
                    (({1'b0, i_draw_x} >= {1'b0, r_x[i]}) && ({1'b0, i_draw_x} < {1'b0, r_x[i]} + {1'b0, PLAT_W}) &&
                     ({1'b0, i_draw_y} >= {1'b0, r_y[i]}) && ({1'b0, i_draw_y} < {1'b0, r_y[i]} + {1'b0, PLAT_H}));
    end

    // State, synchroniser, LFSR, platform sweep, score and registered hit flag
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= S_IDLE;
            r_idx     <= 3'd0;
            r_sync    <= 3'b000;
            r_lfsr    <= LFSR_SEED;
            r_scroll  <= 10'd0;
            r_score   <= 16'd0;
            r_plat_on <= 1'b0;
            for (int i = 0; i < NUM_PLAT; i++) begin
                r_y[i] <= 10'(i * SPACING);
                r_x[i] <= 10'(INIT_X0 + i * INIT_DX);
            end
        end else begin
            r_state   <= w_next;
            r_sync    <= {r_sync[1:0], i_frame_clk};
            r_lfsr    <= {r_lfsr[8:0], r_lfsr[9] ^ r_lfsr[6]};
            r_plat_on <= w_hit;
            if (r_state == S_CALC) begin
                r_scroll <= w_scroll;
                r_idx    <= 3'd0;
            end
            if (r_state == S_UPDATE) begin
                r_idx <= r_idx + 3'd1;
                if (w_wrap) begin
                    r_y[r_idx] <= w_ny - SCREEN_H;
                    r_x[r_idx] <= w_new_x;
                    if (r_score != 16'hFFFF)
                        r_score <= r_score + 16'd1;
                end else begin
                    r_y[r_idx] <= w_ny;
                end
            end
        end
    end
endmodule
